// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//
// UART transmitter with run-time frame format. The data width is fixed at
// elaboration. Parity (none/even/odd) and the number of stop bits (one or two)
// are captured with each word. A word is accepted through a valid/ready
// handshake. It is then sent LSB-first, and each bit lasts OVERSAMPLE baud
// ticks.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  s_tick pulses per bit period (>= 2)
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   s_tick       one-clk baud oversample strobe
//   din          word to send
//   din_valid    din / parity_mode / two_stop are valid
//   din_ready    block can accept a word (high only in IDLE)
//   parity_mode  00 none, 01 even, 10 odd, 11 treated as none
//   two_stop     0 = one stop bit, 1 = two stop bits
//   tx           registered serial line, idle high
//   busy         frame in progress
//   tx_done      one-clk pulse in the cycle that carries the final stop tick
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for a data word: even parity is the XOR of the bits, and odd
    // parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd);
        return (^data) ^ odd;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_q, par_d;
    logic                   two_stop_q, two_stop_d;
    logic                   tx_q, tx_d;
    logic                   bit_end_s;
    logic                   tx_done_s;

    // A bit period ends on the tick that finds the counter at its last value.
    assign bit_end_s = s_tick && (cnt_q == CNT_LAST);

    // Next-state, counter and datapath decode for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        two_stop_d = two_stop_q;
        tx_done_s  = 1'b0;
        tx_d       = 1'b1;

        // The tick counter runs only inside a frame. It is cleared when a
        // word is accepted, so a tick in the acceptance cycle is not counted.
        if ((state_q != ST_IDLE) && s_tick) begin
            cnt_d = bit_end_s ? '0 : (cnt_q + CNT_ONE);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    shift_d    = din;
                    par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_d      = parity_bit(din, parity_mode == 2'b10);
                    two_stop_d = two_stop;
                    cnt_d      = '0;
                    idx_d      = '0;
                    stop_d     = 1'b0;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    // stop_q counts the stop bits already sent. The frame
                    // ends when it matches the latched extra-stop flag.
                    if (stop_q == two_stop_q) begin
                        tx_done_s = 1'b1;
                        stop_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_d  = 1'b1;
                        state_d = ST_STOP;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx is decoded from the next state so that the line changes on the
        // same edge as the state register.
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
        end
    end

    assign din_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign tx        = tx_q;
    assign tx_done   = tx_done_s;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for uart_tx_cfg. There are two instances: an
// 8-bit one and a 7-bit one, both with OVERSAMPLE = 16. Each frame is given
// as a hand-built bit vector {stop(s), parity, data, start}, sent first bit
// first. tx is sampled in the middle of every bit. tx_done must pulse exactly
// on the final tick.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic [8:0] din = 9'h000;
    logic       v8 = 1'b0;
    logic       v7 = 1'b0;
    logic [1:0] pm = 2'b00;
    logic       ts = 1'b0;
    logic       sel = 1'b0;

    logic rdy8, tx8, busy8, done8;
    logic rdy7, tx7, busy7, done7;
    logic rdy_s, tx_s, busy_s, done_s;

    int checks = 0;
    int errors = 0;
    int tick_div = 3;
    int phase = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut8 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .din(din[7:0]),
        .din_valid(v8), .din_ready(rdy8), .parity_mode(pm), .two_stop(ts),
        .tx(tx8), .busy(busy8), .tx_done(done8)
    );

    uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(OS)) dut7 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .din(din[6:0]),
        .din_valid(v7), .din_ready(rdy7), .parity_mode(pm), .two_stop(ts),
        .tx(tx7), .busy(busy7), .tx_done(done7)
    );

    assign rdy_s  = sel ? rdy7  : rdy8;
    assign tx_s   = sel ? tx7   : tx8;
    assign busy_s = sel ? busy7 : busy8;
    assign done_s = sel ? done7 : done8;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle cycles with ticks running; the selected DUT must stay quiet.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_tick = 1'b1;
            #1;
            chk("idle_done", done_s, 1'b0);
            chk("idle_busy", busy_s, 1'b0);
            chk("idle_tx", tx_s, 1'b1);
        end
    endtask

    // Send one frame. The task is entered between clock edges, with the
    // DUT idle.
    task automatic run_frame(input logic s, input logic [8:0] d, input logic [1:0] m,
                             input logic t, input logic [11:0] bits, input int nbits,
                             input logic hold, input logic tick_acc, input logic toggle,
                             input int abort_n);
        int   total;
        int   n;
        logic seen;
        logic aborted;
        sel = s;
        din = d;
        pm  = m;
        ts  = t;
        if (s) v7 = 1'b1; else v8 = 1'b1;
        s_tick = tick_acc;
        #1;
        chk("ready_before", rdy_s, 1'b1);
        chk("tx_before", tx_s, 1'b1);
        chk("busy_before", busy_s, 1'b0);
        @(posedge clk); #1;
        if (!hold) begin
            v7 = 1'b0;
            v8 = 1'b0;
        end
        s_tick  = 1'b0;
        phase   = 0;
        total   = nbits * OS;
        n       = 0;
        seen    = 1'b0;
        aborted = 1'b0;
        #1;
        chk("tx_start_edge", tx_s, 1'b0);
        chk("busy_start", busy_s, 1'b1);
        chk("ready_start", rdy_s, 1'b0);
        for (int c = 0; c < total * tick_div + 64; c++) begin
            if (toggle) begin
                din = din ^ 9'h1FF;
                pm  = pm ^ 2'b11;
                ts  = ~ts;
            end
            s_tick = (phase == 0);
            phase  = (phase + 1) % tick_div;
            if ((abort_n >= 0) && (n == abort_n) && s_tick) begin
                rst = 1'b1;
            end
            #1;
            if (rst) begin
                chk("abort_done_pre", done_s, 1'b0);
                @(posedge clk); #1;
                s_tick = 1'b0;
                #1;
                chk("abort_tx", tx_s, 1'b1);
                chk("abort_busy", busy_s, 1'b0);
                chk("abort_done", done_s, 1'b0);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (s_tick && ((n % OS) == OS / 2)) begin
                chk("tx_bit", tx_s, bits[n / OS]);
            end
            chk("busy_frame", busy_s, 1'b1);
            chk("ready_frame", rdy_s, 1'b0);
            chk("tx_done", done_s, s_tick && (n == total - 1));
            if (done_s) seen = 1'b1;
            if (s_tick) n++;
            @(posedge clk); #1;
            if (n == total) break;
        end
        if (abort_n >= 0) begin
            chk("abort_reached", aborted, 1'b1);
        end else begin
            chk("frame_ticks", n, total);
            chk("done_seen", seen, 1'b1);
            s_tick = 1'b0;
            #1;
            chk("tx_after", tx_s, 1'b1);
            chk("busy_after", busy_s, 1'b0);
            chk("ready_after", rdy_s, 1'b1);
        end
    endtask

    initial begin
        // Reset, with an acceptance attempt that the reset must override.
        rst = 1'b1;
        v8  = 1'b1;
        din = 9'h0A5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx8", tx8, 1'b1);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_ready8", rdy8, 1'b1);
        chk("rst_done8", done8, 1'b0);
        chk("rst_tx7", tx7, 1'b1);
        chk("rst_busy7", busy7, 1'b0);
        v8  = 1'b0;
        rst = 1'b0;
        idle(2);

        // 8N1 0xA5 with a tick in the acceptance cycle: 0,1,0,1,0,0,1,0,1,1
        tick_div = 3;
        run_frame(1'b0, 9'h0A5, 2'b00, 1'b0, {1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b1, 1'b0, -1);
        idle(3);
        // 8E1 0x07: three ones, parity bit 1
        run_frame(1'b0, 9'h007, 2'b01, 1'b0, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        // 8O1 0x07: parity bit 0
        run_frame(1'b0, 9'h007, 2'b10, 1'b0, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        // 7O2 0x00: start, seven 0s, parity 1, two stop bits -> 176 ticks
        run_frame(1'b1, 9'h000, 2'b10, 1'b1, {2'b11, 1'b1, 7'h00, 1'b0}, 11, 1'b0, 1'b0, 1'b0, -1);
        idle(3);

        // Back-to-back with continuous ticks and din_valid held high
        tick_div = 1;
        run_frame(1'b0, 9'h011, 2'b00, 1'b0, {1'b1, 8'h11, 1'b0}, 10, 1'b1, 1'b0, 1'b0, -1);
        run_frame(1'b0, 9'h022, 2'b00, 1'b0, {1'b1, 8'h22, 1'b0}, 10, 1'b0, 1'b0, 1'b0, -1);
        idle(3);
        tick_div = 3;

        // Inputs toggled every cycle mid-frame: 8E1 0x3C (four ones, parity 0)
        run_frame(1'b0, 9'h03C, 2'b01, 1'b0, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1'b0, 1'b0, 1'b1, -1);
        idle(3);
        // Reserved parity mode 11 behaves as none
        run_frame(1'b0, 9'h096, 2'b11, 1'b0, {1'b1, 8'h96, 1'b0}, 10, 1'b0, 1'b0, 1'b0, -1);
        idle(3);

        // Reset in the middle of data bit 3, then a clean 0x5A frame
        run_frame(1'b0, 9'h0C3, 2'b00, 1'b0, {1'b1, 8'hC3, 1'b0}, 10, 1'b0, 1'b0, 1'b0, 4 * OS + 5);
        idle(5);
        run_frame(1'b0, 9'h05A, 2'b00, 1'b0, {1'b1, 8'h5A, 1'b0}, 10, 1'b0, 1'b0, 1'b0, -1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
